tpu_host_seq: RTL and testbench

Host-side command sequencer that drives the TPU memory-mapped port as its initiator and runs one full matrix-multiply job per `start`. On each job it:

- optionally clears the C accumulators;
- streams DIM A rows and DIM B rows from an input valid/ready stream into the TPU;
- issues the matmul command and waits out the systolic pass;
- reads back all C rows as 2·DIM half-row beats on an output valid/ready stream.

It sits between the host DMA/stream fabric and the TPU register port, replacing software-driven register pokes.

---
 rtl/tpu_pkg.sv | 42 ++++
 rtl/tpu_seq_addr_gen.sv | 54 +++++
 rtl/tpu_host_seq.sv | 193 +++++++++++++++++++
 tb/tb_tpu_host_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg
// Shared definitions for the TPU host sequencer: TPU op codes, sequencer
// state encoding, the matmul wait length and TPU address builders.
// Address layout (12 significant bits, op in [11:8]):
//   A/B write : row in [5:3]
//   C access  : row in [6:4], half in [3]
package tpu_pkg;

  localparam int TPU_DIM   = 8;
  // Idle cycles the sequencer waits for one systolic pass.
  localparam int MM_CYCLES = 4 * TPU_DIM;
  // One counter width covers every per-state count (16 C beats, 32 wait cycles).
  localparam int SEQ_CNT_W = $clog2(MM_CYCLES);

  localparam logic [3:0] OP_IDLE = 4'h0;
  localparam logic [3:0] OP_A    = 4'h1;
  localparam logic [3:0] OP_B    = 4'h2;
  localparam logic [3:0] OP_C    = 4'h3;
  localparam logic [3:0] OP_MM   = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_C,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_READ_C,
    S_DONE
  } tpu_seq_state_t;

  // C half-row address: row in [6:4], half in [3].
  function automatic logic [11:0] c_addr(input logic [2:0] row, input logic half);
    return {OP_C, 1'b0, row, half, 3'b000};
  endfunction

  // A/B row write address: row in [5:3].
  function automatic logic [11:0] ab_addr(input logic [3:0] op, input logic [2:0] row);
    return {op, 2'b00, row, 3'b000};
  endfunction

endpackage

// File: rtl/tpu_seq_addr_gen.sv
// tpu_seq_addr_gen
// Per-state beat counter for the host sequencer. It is cleared on every
// state entry, steps on adv_i and flags the last beat of the current state.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   clr_i         restart the count at 0 (wins over adv_i)
//   adv_i         step to the next beat
//   last_idx_i    index of the final beat in the current state
//   row_ab_o      A/B row index (count[2:0])
//   row_c_o       C row index   (count[3:1])
//   half_o        C half select (count[0])
//   last_o        count equals last_idx_i
module tpu_seq_addr_gen
  import tpu_pkg::*;
#(
  parameter int CW = SEQ_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [CW-1:0] last_idx_i,
  output logic [2:0]    row_ab_o,
  output logic [2:0]    row_c_o,
  output logic          half_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign row_ab_o = cnt_q[2:0];
  assign row_c_o  = cnt_q[3:1];
  assign half_o   = cnt_q[0];
  assign last_o   = (cnt_q == last_idx_i);

endmodule

// File: rtl/tpu_host_seq.sv
// tpu_host_seq
// Host-side sequencer that runs one TPU matmul job per start: optional C
// clear, A/B row load from an input stream, matmul start, fixed wait, then
// C readback as half-row beats on an output stream.
// Build option: define TPU_SEQ_CLR_C_EN to include the C clear pass; without
// it C accumulates across jobs (chained K-blocked products).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  job request, sampled in IDLE only
//   busy, done             job in progress / one-cycle end pulse
//   in_valid/ready/data    A then B rows, DIM beats each
//   out_valid/ready/data   C half-rows, 2*DIM beats
//   tpu_addr/r_w/wdata     TPU register port drive (combinational)
//   tpu_rdata              TPU read data, combinational from tpu_addr
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  tpu_seq_state_t state_q, state_d;

  logic                 cnt_clr;
  logic                 cnt_adv;
  logic                 cnt_last;
  logic [SEQ_CNT_W-1:0] last_idx;
  logic [2:0]           row_ab;
  logic [2:0]           row_c;
  logic                 half;

  // Element-wise views of the row/beat buses.
  logic [DATAW-1:0] in_row;
  logic [DATAW-1:0] c_beat;

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_ab_elem
      assign in_row[gi*BITS_AB +: BITS_AB] = in_data[gi*BITS_AB +: BITS_AB];
    end
    for (genvar gi = 0; gi < DIM / 2; gi++) begin : g_c_elem
      assign c_beat[gi*BITS_C +: BITS_C] = tpu_rdata[gi*BITS_C +: BITS_C];
    end
  endgenerate

  tpu_seq_addr_gen #(
    .CW(SEQ_CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .adv_i     (cnt_adv),
    .last_idx_i(last_idx),
    .row_ab_o  (row_ab),
    .row_c_o   (row_c),
    .half_o    (half),
    .last_o    (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter control. Any state change restarts the counter,
  // so the last-beat advance of a state never wraps into the next one.
  always_comb begin
    state_d  = state_q;
    cnt_adv  = 1'b0;
    last_idx = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef TPU_SEQ_CLR_C_EN
          state_d = S_CLR_C;
`else
          state_d = S_LOAD_A;
`endif
        end
      end
`ifdef TPU_SEQ_CLR_C_EN
      S_CLR_C: begin
        cnt_adv  = 1'b1;
        last_idx = SEQ_CNT_W'(2 * DIM - 1);
        if (cnt_last) state_d = S_LOAD_A;
      end
`endif
      S_LOAD_A: begin
        cnt_adv  = in_valid;
        last_idx = SEQ_CNT_W'(DIM - 1);
        if (in_valid && cnt_last) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        cnt_adv  = in_valid;
        last_idx = SEQ_CNT_W'(DIM - 1);
        if (in_valid && cnt_last) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_adv  = 1'b1;
        last_idx = SEQ_CNT_W'(MM_CYCLES - 1);
        if (cnt_last) state_d = S_READ_C;
      end
      S_READ_C: begin
        cnt_adv  = out_ready;
        last_idx = SEQ_CNT_W'(2 * DIM - 1);
        if (out_ready && cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_clr = (state_d != state_q);

  // Outputs: everything defaults to the idle drive; only cycles that issue
  // a TPU transaction override it (a stalled load cycle issues none).
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    tpu_addr  = '0;
    tpu_r_w   = 1'b0;
    tpu_wdata = '0;
    case (state_q)
`ifdef TPU_SEQ_CLR_C_EN
      S_CLR_C: begin
        tpu_addr = ADDRW'(c_addr(row_c, half));
        tpu_r_w  = 1'b1;
      end
`endif
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_addr  = ADDRW'(ab_addr(OP_A, row_ab));
          tpu_r_w   = 1'b1;
          tpu_wdata = in_row;
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_addr  = ADDRW'(ab_addr(OP_B, row_ab));
          tpu_r_w   = 1'b1;
          tpu_wdata = in_row;
        end
      end
      S_START: begin
        tpu_addr = ADDRW'({OP_MM, 8'h00});
        tpu_r_w  = 1'b1;
      end
      S_READ_C: begin
        // Address follows the beat counter, so it holds while out_ready is low.
        tpu_addr  = ADDRW'(c_addr(row_c, half));
        out_valid = 1'b1;
        out_data  = c_beat;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
module tb_tpu_host_seq;

  localparam int DIM = 8;
  localparam int ADDRW = 16;
  localparam int DATAW = 64;
`ifdef TPU_SEQ_CLR_C_EN
  localparam bit CLR_EN  = 1'b1;
  localparam int CLR_CYC = 16;
`else
  localparam bit CLR_EN  = 1'b0;
  localparam int CLR_CYC = 0;
`endif
  localparam int BASE_DONE = 66 + CLR_CYC;

  logic             clk = 1'b0;
  logic             rst_n, start, busy, done;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [DATAW-1:0] in_data, out_data, tpu_wdata, tpu_rdata;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;

  int tests_run = 0;
  int tests_failed = 0;

  tpu_host_seq #(.DIM(8), .BITS_AB(8), .BITS_C(16), .ADDRW(16), .DATAW(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- TPU register-port model ----------------
  logic signed [7:0] tpu_a[8][8];
  logic signed [7:0] tpu_b[8][8];
  logic [15:0]       tpu_c[8][8];
  logic              tpu_wipe = 1'b0;

  always @(posedge clk) begin
    if (tpu_wipe) begin
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) tpu_c[i][j] = 16'h0;
    end else if (tpu_r_w) begin
      case (tpu_addr[11:8])
        4'h1: for (int k = 0; k < 8; k++) tpu_a[tpu_addr[5:3]][k] = tpu_wdata[k*8 +: 8];
        4'h2: for (int k = 0; k < 8; k++) tpu_b[tpu_addr[5:3]][k] = tpu_wdata[k*8 +: 8];
        4'h3: for (int e = 0; e < 4; e++)
                tpu_c[tpu_addr[6:4]][int'(tpu_addr[3])*4 + e] = tpu_wdata[e*16 +: 16];
        4'h4: for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++)
                  tpu_c[i][j] = tpu_c[i][j] + 16'(int'(tpu_a[i][k]) * int'(tpu_b[k][j]));
        default: ;
      endcase
    end
  end

  always_comb begin
    tpu_rdata = '0;
    if (tpu_addr[11:8] == 4'h3)
      for (int e = 0; e < 4; e++)
        tpu_rdata[e*16 +: 16] = tpu_c[tpu_addr[6:4]][int'(tpu_addr[3])*4 + e];
  end

  // ---------------- stimulus matrices and golden model ----------------
  logic signed [7:0] mat_a[8][8];
  logic signed [7:0] mat_b[8][8];
  logic [15:0]       exp_c[8][8];
  logic [63:0]       exp_q[$];

  function automatic logic [63:0] row_word(input int ib);
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (ib < 8) for (int k = 0; k < 8; k++) w[k*8 +: 8] = mat_a[ib][k];
    else if (ib < 16) for (int k = 0; k < 8; k++) w[k*8 +: 8] = mat_b[ib-8][k];
    return w;
  endfunction

  function automatic logic [15:0] exp_caddr(input int b);
    return 16'({4'h3, 1'b0, 3'(b / 2), 1'(b % 2), 3'b000});
  endfunction

  task automatic expect_job();
    int sum;
    logic [63:0] beat;
    if (CLR_EN) for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) exp_c[i][j] = 16'h0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        sum = 0;
        for (int k = 0; k < 8; k++) sum += int'(mat_a[i][k]) * int'(mat_b[k][j]);
        exp_c[i][j] = exp_c[i][j] + 16'(sum);
      end
    for (int b = 0; b < 16; b++) begin
      for (int e = 0; e < 4; e++) beat[e*16 +: 16] = exp_c[b/2][(b%2)*4 + e];
      exp_q.push_back(beat);
    end
  endtask

  // Runs one job from IDLE, checking every cycle's drive against the
  // expected schedule, and returns the cycle in which done was seen.
  task automatic run_job(input string name, input int in_stall_at, input int in_stall_len,
                         input int out_stall_at, input int out_stall_len,
                         input int start_pulse_at, output int done_cycle);
    int cyc, ib, ob, in_left, out_left, clr_n, mm_n, idle_n;
    bit stall_in;
    logic [80:0] got, want;
    logic [63:0] eb;
    cyc = 0; ib = 0; ob = 0; clr_n = 0; mm_n = 0; idle_n = 0;
    in_left = in_stall_len; out_left = out_stall_len; done_cycle = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (done_cycle < 0 && cyc < 400) begin
      @(negedge clk);
      start = (cyc + 1 == start_pulse_at);
      stall_in = (ib == in_stall_at && in_left > 0);
      in_valid = !stall_in && (ib < 16);
      in_data = row_word(ib);
      out_ready = !(ob == out_stall_at && out_left > 0);
      #1;
      got = {tpu_addr, tpu_r_w, tpu_wdata};
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, cyc + 1, busy);
      end
      if (done) begin
        done_cycle = cyc + 1;
      end else if (out_valid) begin
        want = {exp_caddr(ob), 1'b0, 64'h0};
        tests_run++;
        if (got[80:64] !== want[80:64]) begin
          tests_failed++;
          $display("FAIL %s rd_addr beat %0d: got %h/%b want %h/0", name, ob, tpu_addr, tpu_r_w, want[80:65]);
        end
        if (out_ready) begin
          eb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
          tests_run++;
          if (out_data !== eb) begin
            tests_failed++;
            $display("FAIL %s c_beat %0d: got %h want %h", name, ob, out_data, eb);
          end
          ob++;
        end else begin
          out_left--;
        end
      end else if (in_ready) begin
        if (in_valid) want = {16'({(ib < 8) ? 4'h1 : 4'h2, 2'b00, 3'(ib % 8), 3'b000}), 1'b1, in_data};
        else want = '0;
        tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL %s load beat %0d v=%b: got %h want %h", name, ib, in_valid, got, want);
        end
        if (in_valid) ib++;
        else if (stall_in) in_left--;
      end else if (ib == 0) begin
        want = {exp_caddr(clr_n), 1'b1, 64'h0};
        tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL %s clr beat %0d: got %h want %h", name, clr_n, got, want);
        end
        clr_n++;
      end else if (ib == 16) begin
        if (tpu_r_w) begin
          mm_n++;
          want = {16'h0400, 1'b1, 64'h0};
        end else begin
          idle_n++;
          want = '0;
        end
        tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL %s start/wait cycle %0d: got %h want %h", name, cyc + 1, got, want);
        end
      end else begin
        tests_run++; tests_failed++;
        $display("FAIL %s stray cycle %0d: in_ready=%b with %0d rows loaded", name, cyc + 1, in_ready, ib);
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    tests_run++;
    if (done_cycle < 0) begin
      tests_failed++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end
    tests_run++;
    if (clr_n !== CLR_CYC || mm_n !== 1 || idle_n !== 32 || ob !== 16) begin
      tests_failed++;
      $display("FAIL %s phase counts: clr %0d mm %0d wait %0d beats %0d want %0d 1 32 16",
               name, clr_n, mm_n, idle_n, ob, CLR_CYC);
    end
    exp_q.delete();
    $display("[TB] %s: done at cycle %0d", name, done_cycle);
  endtask

  task automatic check_done_at(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [211:0] got;
    got = {busy, done, in_ready, out_valid, out_data, tpu_addr, tpu_r_w, tpu_wdata, 16'h0};
    tests_run++;
    if (got !== '0) begin
      tests_failed++;
      $display("FAIL %s reset outputs: busy %b done %b in_ready %b out_valid %b out_data %h addr %h rw %b wdata %h want all 0",
               name, busy, done, in_ready, out_valid, out_data, tpu_addr, tpu_r_w, tpu_wdata);
    end
    $display("[TB] %s: reset outputs checked", name);
  endtask

  task automatic set_identity();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
        mat_b[i][j] = 8'(i + 1);
      end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = '1;
    tpu_wipe = 1'b1;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) exp_c[i][j] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("test_reset");
    rst_n = 1'b1; tpu_wipe = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_identity();
    int dc;
    set_identity();
    expect_job();
    run_job("test_identity", -1, 0, -1, 0, -1, dc);
    check_done_at("test_identity", dc, BASE_DONE);
  endtask

  task automatic test_back_to_back();
    int dc;
    set_identity();
    expect_job();
    tests_run++;
    if (!CLR_EN && exp_c[3][5] !== 16'd8) begin
      tests_failed++;
      $display("FAIL test_back_to_back golden row3: got %0d want 8", exp_c[3][5]);
    end
    run_job("test_back_to_back", -1, 0, -1, 0, -1, dc);
    check_done_at("test_back_to_back", dc, BASE_DONE);
  endtask

  task automatic test_stalls();
    int dc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = 8'($urandom_range(0, 15)) - 8'sd7;
        mat_b[i][j] = 8'($urandom_range(0, 15)) - 8'sd7;
      end
    expect_job();
    run_job("test_stalls", 3, 3, 5, 2, -1, dc);
    check_done_at("test_stalls", dc, BASE_DONE + 5);
  endtask

  task automatic test_start_ignored();
    int dc;
    set_identity();
    expect_job();
    run_job("test_start_ignored", -1, 0, -1, 0, 40, dc);
    check_done_at("test_start_ignored", dc, BASE_DONE);
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL test_start_ignored after job: busy %b done %b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc, ib, dc;
    set_identity();
    cyc = 0; ib = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (cyc + 1 < 40) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (ib < 16);
      in_data = row_word(ib);
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) ib++;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("test_reset_mid_job");
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL test_reset_mid_job stays idle: busy %b in_ready %b want 0 0", busy, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    // The aborted job may already have issued its matmul; restart from a known C.
    tpu_wipe = 1'b1;
    @(posedge clk);
    #1 tpu_wipe = 1'b0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) exp_c[i][j] = 16'h0;
    expect_job();
    run_job("test_reset_mid_job restart", -1, 0, -1, 0, -1, dc);
    check_done_at("test_reset_mid_job", dc, BASE_DONE);
  endtask

  task automatic test_signed();
    int dc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = 8'($urandom);
        mat_b[i][j] = 8'($urandom);
      end
    for (int k = 0; k < 8; k++) begin
      mat_a[0][k] = -8'sd128;
      mat_b[k][0] = 8'sd127;
      mat_b[k][7] = -8'sd128;
    end
    expect_job();
    run_job("test_signed", -1, 0, 6, 1, -1, dc);
    check_done_at("test_signed", dc, BASE_DONE + 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_identity();
    test_back_to_back();
    test_stalls();
    test_start_ignored();
    test_reset_mid_job();
    test_signed();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
